// File: rtl/udp_rx_port_dispatch.sv
// ============================================================================
// Module   : udp_rx_port_dispatch
// Purpose  : Routes UDP RX header + payload to one of NUM_CH channels by
//            destination port; drains and counts frames that match no channel.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module udp_rx_port_dispatch #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_hdr_valid,
   output logic                 s_hdr_ready,
   input  logic [31:0]          s_src_ip,
   input  logic [15:0]          s_src_port,
   input  logic [15:0]          s_dest_port,
   input  logic [15:0]          s_udp_length,
   input  logic [7:0]           s_payload_tdata,
   input  logic                 s_payload_tvalid,
   output logic                 s_payload_tready,
   input  logic                 s_payload_tlast,
   input  logic                 s_payload_tuser,
   input  logic [NUM_CH*16-1:0] cfg_port,
   input  logic [NUM_CH-1:0]    cfg_en,
   output logic [NUM_CH-1:0]    m_hdr_valid,
   input  logic [NUM_CH-1:0]    m_hdr_ready,
   output logic [31:0]          m_src_ip,
   output logic [15:0]          m_src_port,
   output logic [15:0]          m_udp_length,
   output logic [7:0]           m_payload_tdata,
   output logic [NUM_CH-1:0]    m_payload_tvalid,
   input  logic [NUM_CH-1:0]    m_payload_tready,
   output logic                 m_payload_tlast,
   output logic                 m_payload_tuser,
   output logic [CNT_W-1:0]     stat_drop_cnt,
   output logic [CNT_W-1:0]     stat_err_cnt,
   output logic                 busy
);

   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HDR     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_DROP    = 2'd3
   } state_t;

   state_t             state_q;
   logic [SEL_W-1:0]   sel_q;
   logic [NUM_CH-1:0]  hdr_valid_q;
   logic [31:0]        src_ip_q;
   logic [15:0]        src_port_q;
   logic [15:0]        udp_len_q;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic               w_match_found;
   logic [SEL_W-1:0]   w_match_idx;
   logic               w_beat_last;

   // Scan from the top so the lowest-indexed matching channel wins.
   always_comb begin
      w_match_found = 1'b0;
      w_match_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cfg_en[i] && (cfg_port[16*i +: 16] == s_dest_port)) begin
            w_match_found = 1'b1;
            w_match_idx   = SEL_W'(i);
         end
      end
   end

   always_comb begin
      drop_cnt_d = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
      err_cnt_d  = (err_cnt_q  == '1) ? err_cnt_q  : err_cnt_q  + CNT_W'(1);
   end

   assign s_hdr_ready      = (state_q == S_IDLE);
   assign s_payload_tready = (state_q == S_PAYLOAD) ? m_payload_tready[sel_q]
                                                    : (state_q == S_DROP);
   assign w_beat_last      = s_payload_tvalid && s_payload_tready && s_payload_tlast;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         assign m_payload_tvalid[g] = (state_q == S_PAYLOAD) && (sel_q == SEL_W'(g))
                                      && s_payload_tvalid;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         hdr_valid_q <= '0;
         src_ip_q    <= '0;
         src_port_q  <= '0;
         udp_len_q   <= '0;
         drop_cnt_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (s_hdr_valid) begin
                  src_ip_q   <= s_src_ip;
                  src_port_q <= s_src_port;
                  udp_len_q  <= s_udp_length;
                  if (w_match_found) begin
                     sel_q       <= w_match_idx;
                     hdr_valid_q <= NUM_CH'(1) << w_match_idx;
                     state_q     <= S_HDR;
                  end else begin
                     drop_cnt_q <= drop_cnt_d;
                     state_q    <= S_DROP;
                  end
               end
            end
            S_HDR: begin
               if (m_hdr_ready[sel_q]) begin
                  hdr_valid_q <= '0;
                  state_q     <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (w_beat_last) begin
                  state_q <= S_IDLE;
                  if (s_payload_tuser) err_cnt_q <= err_cnt_d;
               end
            end
            S_DROP: begin
               if (w_beat_last) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign m_hdr_valid     = hdr_valid_q;
   assign m_src_ip        = src_ip_q;
   assign m_src_port      = src_port_q;
   assign m_udp_length    = udp_len_q;
   assign m_payload_tdata = s_payload_tdata;
   assign m_payload_tlast = s_payload_tlast;
   assign m_payload_tuser = s_payload_tuser;
   assign stat_drop_cnt   = drop_cnt_q;
   assign stat_err_cnt    = err_cnt_q;
   assign busy            = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_udp_rx_port_dispatch.sv
// ============================================================================
// Module   : tb_udp_rx_port_dispatch
// Purpose  : Directed, table-driven bench for udp_rx_port_dispatch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_udp_rx_port_dispatch;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   logic                 clk;
   logic                 rst_n;
   logic                 s_hdr_valid;
   logic                 s_hdr_ready;
   logic [31:0]          s_src_ip;
   logic [15:0]          s_src_port;
   logic [15:0]          s_dest_port;
   logic [15:0]          s_udp_length;
   logic [7:0]           s_payload_tdata;
   logic                 s_payload_tvalid;
   logic                 s_payload_tready;
   logic                 s_payload_tlast;
   logic                 s_payload_tuser;
   logic [NUM_CH*16-1:0] cfg_port;
   logic [NUM_CH-1:0]    cfg_en;
   logic [NUM_CH-1:0]    m_hdr_valid;
   logic [NUM_CH-1:0]    m_hdr_ready;
   logic [31:0]          m_src_ip;
   logic [15:0]          m_src_port;
   logic [15:0]          m_udp_length;
   logic [7:0]           m_payload_tdata;
   logic [NUM_CH-1:0]    m_payload_tvalid;
   logic [NUM_CH-1:0]    m_payload_tready;
   logic                 m_payload_tlast;
   logic                 m_payload_tuser;
   logic [CNT_W-1:0]     stat_drop_cnt;
   logic [CNT_W-1:0]     stat_err_cnt;
   logic                 busy;

   udp_rx_port_dispatch #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
      .s_src_ip(s_src_ip), .s_src_port(s_src_port),
      .s_dest_port(s_dest_port), .s_udp_length(s_udp_length),
      .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid),
      .s_payload_tready(s_payload_tready), .s_payload_tlast(s_payload_tlast),
      .s_payload_tuser(s_payload_tuser),
      .cfg_port(cfg_port), .cfg_en(cfg_en),
      .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
      .m_src_ip(m_src_ip), .m_src_port(m_src_port), .m_udp_length(m_udp_length),
      .m_payload_tdata(m_payload_tdata), .m_payload_tvalid(m_payload_tvalid),
      .m_payload_tready(m_payload_tready), .m_payload_tlast(m_payload_tlast),
      .m_payload_tuser(m_payload_tuser),
      .stat_drop_cnt(stat_drop_cnt), .stat_err_cnt(stat_err_cnt), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int exp_drop = 0;
   int exp_err  = 0;

   typedef struct {
      logic [63:0] ports;
      logic [3:0]  en;
      logic [15:0] dport;
      int          nbytes;
      logic        tuser;
      logic [3:0]  exp_oh;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Sends one frame with all handshakes driven by the bench; exp_oh==0 means drop.
   task automatic run_frame(input logic [15:0] dport, input int nbytes, input logic tuser_last,
                            input logic [3:0] exp_oh, input int hdr_stall,
                            input bit toggle_rdy, input bit clr_cfg, input bit do_chk);
      logic [31:0] ip;
      logic [15:0] sp, ln;
      bit          drop, rdy, hs;
      int          k, cyc;
      drop = (exp_oh == 4'b0000);
      ip = {16'hC0A8, dport};
      sp = dport ^ 16'h5A5A;
      ln = 16'(nbytes + 8);
      s_src_ip = ip; s_src_port = sp; s_udp_length = ln; s_dest_port = dport;
      s_hdr_valid = 1'b1;
      @(negedge clk);
      if (do_chk) check("hdr_ready_idle", 64'(s_hdr_ready), 64'd1);
      @(posedge clk); #1;
      s_hdr_valid = 1'b0;
      s_dest_port = 16'hFFFF;
      s_src_ip = 32'hDEAD_BEEF; s_src_port = 16'h0; s_udp_length = 16'h0;
      if (clr_cfg) cfg_en = '0;
      if (drop) begin
         if (exp_drop < (1 << CNT_W) - 1) exp_drop++;
      end else begin
         for (int s = 0; s <= hdr_stall; s++) begin
            m_hdr_ready = (s == hdr_stall) ? '1 : '0;
            @(negedge clk);
            if (do_chk) begin
               check("m_hdr_valid", 64'(m_hdr_valid), 64'(exp_oh));
               check("m_src_ip", 64'(m_src_ip), 64'(ip));
               check("m_src_port", 64'(m_src_port), 64'(sp));
               check("m_udp_length", 64'(m_udp_length), 64'(ln));
               check("hdr_ready_busy", 64'(s_hdr_ready), 64'd0);
            end
            @(posedge clk); #1;
         end
         m_hdr_ready = '0;
      end
      k = 0; cyc = 0;
      while (k < nbytes && cyc < 200) begin
         rdy = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
         s_payload_tvalid = 1'b1;
         s_payload_tdata  = 8'(8'hA0 + k);
         s_payload_tlast  = (k == nbytes - 1);
         s_payload_tuser  = (k == nbytes - 1) ? tuser_last : 1'b0;
         m_payload_tready = rdy ? '1 : '0;
         hs = drop ? 1'b1 : rdy;
         @(negedge clk);
         if (do_chk) begin
            check("m_payload_tvalid", 64'(m_payload_tvalid), 64'(exp_oh));
            check("s_payload_tready", 64'(s_payload_tready), 64'(hs));
            check("m_hdr_valid_pl", 64'(m_hdr_valid), 64'd0);
            if (!drop) check("m_payload_tdata", 64'(m_payload_tdata), 64'(8'hA0 + k));
            if (!drop) check("m_payload_tlast", 64'(m_payload_tlast), 64'(k == nbytes - 1));
         end
         @(posedge clk); #1;
         if (hs) k++;
         cyc++;
      end
      s_payload_tvalid = 1'b0; s_payload_tlast = 1'b0; s_payload_tuser = 1'b0;
      m_payload_tready = '0;
      if (k < nbytes) check("payload_timeout", 64'(k), 64'(nbytes));
      if (!drop && tuser_last && exp_err < (1 << CNT_W) - 1) exp_err++;
      @(negedge clk);
      if (do_chk) begin
         check("busy_after_tlast", 64'(busy), 64'd0);
         check("stat_drop_cnt", 64'(stat_drop_cnt), 64'(exp_drop));
         check("stat_err_cnt", 64'(stat_err_cnt), 64'(exp_err));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      s_hdr_valid = 0; s_src_ip = 0; s_src_port = 0; s_dest_port = 0; s_udp_length = 0;
      s_payload_tdata = 0; s_payload_tvalid = 0; s_payload_tlast = 0; s_payload_tuser = 0;
      cfg_port = '0; cfg_en = '0; m_hdr_ready = '0; m_payload_tready = '0;

      //             ports {ch3,ch2,ch1,ch0}                  en       dport   n   tuser exp_oh
      vecs[0] = '{ {16'd0,    16'd0,    16'd6000, 16'd5000}, 4'b0011, 16'd6000, 4, 1'b0, 4'b0010};
      vecs[1] = '{ {16'd0,    16'd0,    16'd6000, 16'd5000}, 4'b0011, 16'd7000, 10, 1'b0, 4'b0000};
      vecs[2] = '{ {16'd0,    16'd5000, 16'd0,    16'd5000}, 4'b0101, 16'd5000, 3, 1'b0, 4'b0001};
      vecs[3] = '{ {16'd0,    16'd5000, 16'd0,    16'd5000}, 4'b0100, 16'd5000, 3, 1'b0, 4'b0100};
      vecs[4] = '{ {16'd1234, 16'd0,    16'd0,    16'd0},    4'b1000, 16'd1234, 1, 1'b0, 4'b1000};
      vecs[5] = '{ {16'd1234, 16'd0,    16'd0,    16'd0},    4'b0000, 16'd1234, 1, 1'b0, 4'b0000};
      vecs[6] = '{ {16'd0,    16'd0,    16'd6000, 16'd5000}, 4'b0011, 16'd6000, 2, 1'b1, 4'b0010};

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_m_hdr_valid", 64'(m_hdr_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_src_ip", 64'(m_src_ip), 64'd0);
      check("rst_drop_cnt", 64'(stat_drop_cnt), 64'd0);
      check("rst_err_cnt", 64'(stat_err_cnt), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 7; v++) begin
         cfg_port = vecs[v].ports;
         cfg_en   = vecs[v].en;
         run_frame(vecs[v].dport, vecs[v].nbytes, vecs[v].tuser, vecs[v].exp_oh, 0, 1'b0, 1'b0, 1'b1);
      end

      // Header back-pressure, toggling payload ready, config cleared mid-frame.
      cfg_port = {16'd0, 16'd0, 16'd6000, 16'd5000};
      cfg_en   = 4'b0011;
      run_frame(16'd5000, 6, 1'b0, 4'b0001, 5, 1'b1, 1'b1, 1'b1);

      // Saturating drop counter: 2^CNT_W + 3 unmatched frames.
      cfg_en = '0;
      for (int d = 0; d < (1 << CNT_W) + 3; d++)
         run_frame(16'd7000, 1, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("drop_cnt_saturated", 64'(stat_drop_cnt), 64'((1 << CNT_W) - 1));
      check("err_cnt_kept", 64'(stat_err_cnt), 64'd1);
      @(posedge clk); #1;

      // Reset asserted while a routed frame is mid-payload.
      cfg_en = 4'b0001;
      cfg_port = {16'd0, 16'd0, 16'd0, 16'd5000};
      s_dest_port = 16'd5000; s_src_ip = 32'h0A00_0001; s_hdr_valid = 1'b1;
      @(posedge clk); #1;
      s_hdr_valid = 1'b0;
      m_hdr_ready = '1;
      @(posedge clk); #1;
      m_hdr_ready = '0;
      s_payload_tvalid = 1'b1; s_payload_tdata = 8'h11; m_payload_tready = '0;
      @(negedge clk);
      check("pre_rst_tvalid", 64'(m_payload_tvalid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_tvalid", 64'(m_payload_tvalid), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_tready", 64'(s_payload_tready), 64'd0);
      check("rst_mid_drop_cnt", 64'(stat_drop_cnt), 64'd0);
      check("rst_mid_err_cnt", 64'(stat_err_cnt), 64'd0);
      check("rst_mid_src_ip", 64'(m_src_ip), 64'd0);
      s_payload_tvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
